// File: rtl/guarded_counter_checker.sv
// Receive-side monitor for a guarded counter stream: checks the guard counts and continuity
// of each sample, keeps a saturating error total and latches an alarm after a run of faults.
module guarded_counter_checker #(
    parameter int unsigned width        = 8,
    parameter int unsigned guard_bits   = 4,
    parameter int unsigned err_cnt_bits = 8,
    parameter int unsigned alarm_thresh = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [width-1:0]        cnt_in,
    input  logic [guard_bits-1:0]   even_in,
    input  logic [guard_bits-1:0]   odd_in,
    input  logic                    alarm_clr,
    output logic                    out_valid,
    output logic                    err_guard,
    output logic                    err_seq,
    output logic [err_cnt_bits-1:0] err_total,
    output logic                    alarm
);

    localparam int unsigned consec_bits = $clog2(alarm_thresh + 1);

    typedef enum logic [1:0] {
        StAcquire,
        StTrack,
        StAlarm
    } state_e;

    state_e                  state_q, state_d;
    logic [width-1:0]        prev_q, prev_d, prev_inc;
    logic [consec_bits-1:0]  consec_q, consec_d;
    logic [err_cnt_bits-1:0] err_total_q, err_total_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_guard_q, err_guard_d;
    logic                    err_seq_q, err_seq_d;
    logic [guard_bits-1:0]   exp_even, exp_odd;
    logic                    guard_bad, seq_bad, faulty;

    // Guard counts wrap naturally at guard_bits, matching the producer's truncation.
    always_comb begin
        exp_even = '0;
        exp_odd  = '0;
        for (int i = 0; i < int'(width); i++) begin
            if (i % 2 == 0) begin
                exp_even = exp_even + guard_bits'(cnt_in[i]);
            end else begin
                exp_odd = exp_odd + guard_bits'(cnt_in[i]);
            end
        end
    end

    assign prev_inc  = prev_q + width'(1);
    assign guard_bad = in_valid && ((even_in != exp_even) || (odd_in != exp_odd));
    assign seq_bad   = in_valid && (state_q != StAcquire) && (cnt_in != prev_inc);
    assign faulty    = guard_bad || seq_bad;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        consec_d    = consec_q;
        err_total_d = err_total_q;
        out_valid_d = 1'b0;
        err_guard_d = 1'b0;
        err_seq_d   = 1'b0;

        if (in_valid) begin
            out_valid_d = 1'b1;
            err_guard_d = guard_bad;
            err_seq_d   = seq_bad;
            // Resynchronise on whatever arrived, faulty or not.
            prev_d      = cnt_in;
            if (faulty) begin
                if (err_total_q != '1) begin
                    err_total_d = err_total_q + err_cnt_bits'(1);
                end
                if (consec_q < consec_bits'(alarm_thresh)) begin
                    consec_d = consec_q + consec_bits'(1);
                end
            end else begin
                consec_d = '0;
            end
        end

        unique case (state_q)
            StAcquire: begin
                if (in_valid) begin
                    state_d = StTrack;
                end
            end
            StTrack: begin
                if (consec_d >= consec_bits'(alarm_thresh)) begin
                    state_d = StAlarm;
                end
            end
            StAlarm: begin
                // A clear beats a coincident fault; that sample is still totalled above.
                if (alarm_clr) begin
                    state_d  = StAcquire;
                    consec_d = '0;
                end
            end
            default: state_d = StAcquire;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= StAcquire;
            prev_q      <= '0;
            consec_q    <= '0;
            err_total_q <= '0;
            out_valid_q <= 1'b0;
            err_guard_q <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            consec_q    <= consec_d;
            err_total_q <= err_total_d;
            out_valid_q <= out_valid_d;
            err_guard_q <= err_guard_d;
            err_seq_q   <= err_seq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign err_guard = err_guard_q;
    assign err_seq   = err_seq_q;
    assign err_total = err_total_q;
    assign alarm     = (state_q == StAlarm);

endmodule

// File: doc/guarded_counter_checker.md
# guarded_counter_checker

Receiving-side monitor for the guarded unsigned counter stream. It samples a counter value together with its even-position and odd-position set-bit counts (guard counts). It recomputes both counts and checks counter continuity (each value = previous + 1, modulo 2^width). Results are flagged per sample; errors are accumulated, and an alarm state machine latches after a run of consecutive faulty samples. It sits downstream of any counter/guard producer, e.g. across a radiation-exposed link or register boundary.

## Interface
- width, 8, counter value width in bits
- guard_bits, 4, width of each guard count; comparison is modulo 2^guard_bits
- err_cnt_bits, 8, width of saturating total-error counter
- alarm_thresh, 3, consecutive faulty samples that trigger ALARM (≥1)

- clk  input  1  clock, all logic on rising edge
- rstn  input  1  synchronous, active-high reset (rstn=1 clears all state at the clock edge)
- in_valid  input  1  sample strobe; cnt_in/even_in/odd_in valid when 1
- cnt_in  input  width  received counter value
- even_in  input  guard_bits  received count of set bits at positions 0,2,4,…
- odd_in  input  guard_bits  received count of set bits at positions 1,3,5,…
- alarm_clr  input  1  request to leave ALARM
- out_valid  output  1  result strobe, one cycle after accepted sample
- err_guard  output  1  either guard count mismatched (qualified by out_valid)
- err_seq  output  1  continuity violated (qualified by out_valid)
- err_total  output  err_cnt_bits  saturating count of faulty samples
- alarm  output  1  high while in ALARM

## Operation
- Expected guards: popcount of even/odd bit positions of cnt_in, truncated to guard_bits LSBs; err_guard = (even_in≠exp_even) | (odd_in≠exp_odd).
- Faulty sample = err_guard | err_seq.
- State machine:
  - ACQUIRE (reset state): the first valid sample loads prev; err_seq=0, err_guard is still evaluated; go to TRACK.
  - TRACK: err_seq = (cnt_in ≠ prev+1 mod 2^width). prev loads cnt_in on every valid sample, even faulty ones (resynchronise on the received value). Consecutive-fault counter increments on a faulty sample and clears on a clean one. On reaching alarm_thresh, go to ALARM.
  - ALARM: checking continues, and err_total keeps counting. alarm=1. With alarm_clr=1, go to ACQUIRE and clear the consecutive counter; err_total is kept.
- in_valid=0: no state change, out_valid=0, err flags 0.
- err_total: increments by 1 per faulty sample and holds at 2^err_cnt_bits−1.
- alarm_clr is ignored outside ALARM. If alarm_clr and a faulty sample arrive in the same cycle in ALARM, the clear wins: go to ACQUIRE, and the sample still counts in err_total.
- Wrap: prev=2^width−1 followed by cnt_in=0 is valid continuity.

## Timing
- Reset (rstn=1 at an edge): out_valid=0, err_guard=0, err_seq=0, err_total=0, alarm=0, prev=0, consecutive=0, state=ACQUIRE. Reset overrides in_valid/alarm_clr in the same cycle; a sample present during reset is discarded.
- Latency: sample accepted at edge N gives out_valid/err_guard/err_seq at edge N+1, each held one cycle.
- err_total updates at edge N+1 with the flags.
- Consecutive counter updates at edge N+1. If the threshold is hit by sample N, alarm rises at edge N+1, coincident with that sample's flags.
- Back-to-back samples every cycle are supported; throughput is 1 sample/cycle, no backpressure.
- alarm_clr at edge M: alarm=0 after edge M; the next valid sample re-acquires.

## Test plan
- width=8, guard_bits=4. After reset, send 0xFE(e=3,o=4), 0xFF(e=4,o=4), 0x00(e=0,o=0) on consecutive cycles -> three out_valid pulses, all err flags 0, err_total=0 (wrap accepted).
- Send 0xAA(e=0,o=4), then 0xAB with e=0,o=4 (true e=1) -> second result err_guard=1, err_seq=0, err_total=1.
- Send 0x10, 0x12 with correct guards -> second result err_seq=1, err_guard=0; then 0x13 -> clean (resynchronised).
- Three consecutive faulty samples (alarm_thresh=3) -> alarm=1 on the edge of the third result; then alarm_clr=1 -> alarm=0, next sample 0x55(e=4,o=0) gives err_seq=0 (ACQUIRE).
- Force 300 faulty samples with err_cnt_bits=8 -> err_total saturates at 255.
- Assert rstn for one cycle mid-stream, with in_valid=1 and an alarm active -> all outputs 0 next cycle, first sample after reset gives err_seq=0.
